snoop_bus_arbiter: RTL

- Responder/controller end of the data-cache snoop bus.
- Arbitrates bus acquisition among NUM_CACHES snooping data caches and captures the winner's command.
- Broadcasts the command to every other cache, collects their snoop replies, and returns the per-requester bus_ready / bus_resp handshake plus any peer-supplied line.
- Sits between the per-core snoopbus data caches and the shared memory path.

---
 rtl/snoop_bus_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/snoop_bus_arbiter.sv
// rtl/snoop_bus_arbiter.sv - round-robin snoop bus arbiter with peer snoop broadcast and response collection
module snoop_bus_arbiter #(
    parameter int NUM_CACHES    = 2,
    parameter int SNOOP_TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CACHES-1:0]     req_query,
    input  logic [NUM_CACHES*32-1:0]  req_addr,
    input  logic [NUM_CACHES*3-1:0]   req_cmd,
    output logic [NUM_CACHES-1:0]     bus_ready,
    output logic [NUM_CACHES*2-1:0]   bus_resp,
    output logic [255:0]              resp_data,
    output logic [NUM_CACHES-1:0]     snoop_valid,
    output logic [31:0]               snoop_addr,
    output logic [2:0]                snoop_cmd,
    input  logic [NUM_CACHES-1:0]     snoop_ack,
    input  logic [NUM_CACHES-1:0]     snoop_hit,
    input  logic [NUM_CACHES*256-1:0] snoop_data
);

    localparam int          IW       = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;
    localparam logic [15:0] TMO      = 16'(SNOOP_TIMEOUT);
    localparam logic [2:0]  CMD_READ = 3'b001;
    localparam logic [2:0]  CMD_INV  = 3'b010;

    typedef enum logic [1:0] {IDLE, CAPTURE, SNOOP, RESP} state_t;

    state_t                      state;
    logic [IW-1:0]               win;
    logic [IW-1:0]               rr_ptr;
    logic [NUM_CACHES-1:0]       done_q;
    logic [NUM_CACHES-1:0]       hit_q;
    logic [NUM_CACHES*256-1:0]   data_q;
    logic [15:0]                 tmo_cnt;

    logic [NUM_CACHES-1:0]       rot;
    logic [IW-1:0]               off;
    logic [IW:0]                 sum;
    logic [IW-1:0]               pick;
    logic [IW-1:0]               pick_next;
    logic [NUM_CACHES-1:0]       pick_oh;
    logic [NUM_CACHES-1:0]       win_oh;
    logic [NUM_CACHES-1:0]       peers;
    logic [2:0]                  cap_cmd;
    logic [31:0]                 cap_addr;
    logic [255:0]                sel_data;
    logic [NUM_CACHES*2-1:0]     resp_ack;
    logic [NUM_CACHES*2-1:0]     resp_miss;
    logic                        all_done;
    logic                        timed_out;

    // Rotate requests so bit 0 is the current round-robin start, then take the lowest set bit.
    always_comb begin
        rot = NUM_CACHES'({req_query, req_query} >> rr_ptr);
        off = '0;
        for (int k = NUM_CACHES - 1; k >= 0; k--) begin
            if (rot[k]) off = IW'(k);
        end
        sum = {1'b0, rr_ptr} + {1'b0, off};
        if (sum >= (IW+1)'(NUM_CACHES)) sum = sum - (IW+1)'(NUM_CACHES);
        pick      = sum[IW-1:0];
        pick_next = (pick == IW'(NUM_CACHES - 1)) ? '0 : pick + 1'b1;
        pick_oh   = {{(NUM_CACHES-1){1'b0}}, 1'b1} << pick;
    end

    always_comb begin
        win_oh    = {{(NUM_CACHES-1){1'b0}}, 1'b1} << win;
        peers     = ~win_oh;
        cap_cmd   = '0;
        cap_addr  = '0;
        sel_data  = '0;
        resp_ack  = '0;
        resp_miss = '0;
        for (int k = 0; k < NUM_CACHES; k++) begin
            if (win == IW'(k)) begin
                cap_cmd  = req_cmd[k*3 +: 3];
                cap_addr = req_addr[k*32 +: 32];
            end
            resp_ack[k*2 +: 2]  = win_oh[k] ? 2'b01 : 2'b00;
            resp_miss[k*2 +: 2] = win_oh[k] ? 2'b10 : 2'b00;
        end
        // Lowest-index hitting peer supplies the line.
        for (int k = NUM_CACHES - 1; k >= 0; k--) begin
            if (hit_q[k]) sel_data = data_q[k*256 +: 256];
        end
        all_done  = &(done_q | win_oh);
        timed_out = (TMO != 16'd0) && ((tmo_cnt + 16'd1) == TMO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            win         <= '0;
            rr_ptr      <= '0;
            done_q      <= '0;
            hit_q       <= '0;
            data_q      <= '0;
            tmo_cnt     <= '0;
            bus_ready   <= '0;
            bus_resp    <= '0;
            resp_data   <= '0;
            snoop_valid <= '0;
            snoop_addr  <= '0;
            snoop_cmd   <= '0;
        end else begin
            bus_ready <= '0;
            bus_resp  <= '0;
            resp_data <= '0;
            case (state)
                IDLE: begin
                    if (|req_query) begin
                        win       <= pick;
                        rr_ptr    <= pick_next;
                        bus_ready <= pick_oh;
                        state     <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (cap_cmd == CMD_READ || cap_cmd == CMD_INV) begin
                        snoop_cmd   <= cap_cmd;
                        snoop_addr  <= cap_addr & ~32'h1F;
                        snoop_valid <= peers;
                        done_q      <= '0;
                        hit_q       <= '0;
                        data_q      <= '0;
                        tmo_cnt     <= '0;
                        state       <= SNOOP;
                    end else begin
                        bus_resp <= resp_miss;
                        state    <= IDLE;
                    end
                end
                SNOOP: begin
                    for (int k = 0; k < NUM_CACHES; k++) begin
                        if (peers[k] && !done_q[k] && snoop_ack[k]) begin
                            done_q[k]      <= 1'b1;
                            hit_q[k]       <= snoop_hit[k];
                            snoop_valid[k] <= 1'b0;
                            if (snoop_hit[k]) data_q[k*256 +: 256] <= snoop_data[k*256 +: 256];
                        end
                    end
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (all_done || timed_out) begin
                        snoop_valid <= '0;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (snoop_cmd == CMD_READ) begin
                        if (|hit_q) begin
                            bus_resp  <= resp_ack;
                            resp_data <= sel_data;
                        end else begin
                            bus_resp <= resp_miss;
                        end
                    end else begin
                        bus_resp <= resp_ack;
                    end
                    snoop_cmd  <= '0;
                    snoop_addr <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
